// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// framing-engine states and status-word bit positions.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam int ST_FULL   = 15;
  localparam int ST_ACTIVE = 14;
  localparam int ST_EMPTY  = 13;
  localparam int ST_OVF    = 12;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, power-of-two depth, head word visible on rdata.
// A push while full is ignored even if a pop happens on the same edge.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone decide validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed framing engine with memory-mapped
// load/in/out access and back-to-back frames on TX.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  output logic        TX,
  output logic [15:0] out
);

  localparam int STOP_CYC = STOP_BITS * CLKS_PER_BIT;
  localparam int BW       = $clog2(STOP_CYC);
  localparam int CNTW     = $clog2(DATA_BITS);
  localparam int FCW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BW-1:0]   BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   STOP_LAST = BW'(STOP_CYC - 1);
  localparam logic [CNTW-1:0] DATA_LAST = CNTW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CNTW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;
  logic                 launch;
  logic                 bit_end;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCW-1:0]       fifo_count;
  logic                 unused_in_bits;

  assign unused_in_bits = ^in[14:DATA_BITS];
  assign fifo_push      = load && !in[15];
  assign fifo_pop       = launch;
  assign bit_end        = (baud_q == BIT_LAST);

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (in[DATA_BITS-1:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value is given its hold value first, so no branch can infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ovf_d   = ovf_q;
    launch  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) launch = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        // The last stop cycle chains straight into the next start bit when data is waiting.
        if (baud_q == STOP_LAST) begin
          if (!fifo_empty) launch = 1'b1;
          else             state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (launch) begin
      state_d = S_START;
      baud_d  = '0;
      tx_d    = 1'b0;
      shift_d = fifo_rdata;
      par_d   = (PARITY == PAR_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);
    end

    if (load && in[15])                ovf_d = 1'b0;
    else if (fifo_push && fifo_full)   ovf_d = 1'b1;
  end

  assign TX = tx_q;

  always_comb begin
    out            = '0;
    out[ST_FULL]   = fifo_full;
    out[ST_ACTIVE] = (state_q != S_IDLE);
    out[ST_EMPTY]  = fifo_empty;
    out[ST_OVF]    = ovf_q;
    out[8:0]       = 9'(fifo_count);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: five differently configured transmitters, a status
// model in the writer and a frame scoreboard compared cycle by cycle on TX.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int NDUT = 5;
  localparam int CPB  = 4;
  localparam int DB  [NDUT] = '{8, 8, 7, 7, 8};
  localparam int PAR [NDUT] = '{0, 0, 1, 2, 0};
  localparam int SB  [NDUT] = '{1, 1, 1, 1, 2};
  localparam int DEP [NDUT] = '{16, 4, 16, 16, 16};

  typedef struct {
    logic [63:0] wave;
    int          len;
    logic [7:0]  data;
  } frame_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NDUT-1:0] load;
  logic [15:0]     din  [NDUT];
  logic [NDUT-1:0] tx;
  logic [15:0]     dout [NDUT];

  int     errors = 0;
  int     checks = 0;
  frame_t sb_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_dut0 (.clk(clk), .reset(reset), .load(load[0]), .in(din[0]), .TX(tx[0]), .out(dout[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_dut1 (.clk(clk), .reset(reset), .load(load[1]), .in(din[1]), .TX(tx[1]), .out(dout[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_dut2 (.clk(clk), .reset(reset), .load(load[2]), .in(din[2]), .TX(tx[2]), .out(dout[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_dut3 (.clk(clk), .reset(reset), .load(load[3]), .in(din[3]), .TX(tx[3]), .out(dout[3]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16))
    u_dut4 (.clk(clk), .reset(reset), .load(load[4]), .in(din[4]), .TX(tx[4]), .out(dout[4]));

  // Expected TX level for every clock of one frame, bit 0 = first start-bit cycle.
  function automatic frame_t build_frame(input int idx, input logic [7:0] data);
    frame_t     f;
    logic [7:0] mask;
    logic       p;
    int         pos;
    mask   = 8'((1 << DB[idx]) - 1);
    p      = ^(data & mask);
    if (PAR[idx] == 2) p = ~p;
    f.wave = '1;
    f.data = data;
    pos    = 0;
    for (int c = 0; c < CPB; c++) begin f.wave[pos] = 1'b0; pos++; end
    for (int b = 0; b < DB[idx]; b++)
      for (int c = 0; c < CPB; c++) begin f.wave[pos] = data[b]; pos++; end
    if (PAR[idx] != 0)
      for (int c = 0; c < CPB; c++) begin f.wave[pos] = p; pos++; end
    for (int c = 0; c < SB[idx] * CPB; c++) begin f.wave[pos] = 1'b1; pos++; end
    f.len = pos;
    return f;
  endfunction

  // One word per clock from idle; models count/full/empty/overflow/active after each edge.
  task automatic write_seq(input int idx, input logic [15:0] words [$]);
    int   occ    = 0;
    int   pre;
    bit   popped = 1'b0;
    bit   ovf    = 1'b0;
    bit   acc;
    bit   pop_now;
    logic [15:0] exp_out;
    for (int k = 0; k < words.size(); k++) begin
      din[idx]  = words[k];
      load[idx] = 1'b1;
      pre     = occ;
      acc     = 1'b0;
      pop_now = !popped && (pre > 0);
      if (words[k][15]) ovf = 1'b0;
      else if (pre == DEP[idx]) ovf = 1'b1;
      else begin
        acc = 1'b1;
        sb_q.push_back(build_frame(idx, words[k][7:0]));
      end
      occ = pre + int'(acc) - int'(pop_now);
      if (pop_now) popped = 1'b1;
      @(negedge clk);
      exp_out = {occ == DEP[idx], popped, occ == 0, ovf, 3'b000, 9'(occ)};
      checks++;
      if (dout[idx] !== exp_out)
        $display("FAIL status_after_write dut%0d word%0d: got %h expected %h", idx, k, dout[idx], exp_out);
      if (dout[idx] !== exp_out) errors++;
    end
    load[idx] = 1'b0;
    din[idx]  = 16'h0000;
  endtask

  task automatic wait_start(input int idx, output int lat);
    lat = 0;
    while (tx[idx] !== 1'b0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Captures n frames; frames after the first must follow with no idle cycle.
  task automatic rx_frames(input int idx, input int n);
    int          lat;
    int          len;
    frame_t      e;
    logic [63:0] got;
    bit          extra;
    wait_start(idx, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL start_latency dut%0d: got %0d expected 2 negedges", idx, lat);
    end
    if (tx[idx] !== 1'b0) return;
    len = 0;
    for (int f = 0; f < n; f++) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty dut%0d frame%0d: got frame expected none", idx, f);
        return;
      end
      e   = sb_q.pop_front();
      len = e.len;
      got = '1;
      for (int c = 0; c < e.len; c++) begin
        got[c] = tx[idx];
        if (c == e.len - 1) begin
          checks++;
          if (dout[idx][14] !== 1'b1) begin
            errors++;
            $display("FAIL active_last_stop dut%0d frame%0d: got %b expected 1", idx, f, dout[idx][14]);
          end
        end
        if (c < e.len - 1) @(negedge clk);
      end
      checks++;
      if (got !== e.wave) begin
        errors++;
        $display("FAIL frame_wave dut%0d data %h: got %h expected %h", idx, e.data, got, e.wave);
      end
      @(negedge clk);
    end
    checks++;
    if (tx[idx] !== 1'b1 || dout[idx] !== 16'h2000) begin
      errors++;
      $display("FAIL idle_after_frames dut%0d: got tx=%b out=%h expected tx=1 out=2000", idx, tx[idx], dout[idx]);
    end
    extra = 1'b0;
    repeat (2 * len) begin
      @(negedge clk);
      if (tx[idx] !== 1'b1) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL extra_frame dut%0d: got activity on TX expected idle", idx);
    end
  endtask

  task automatic run_case(input int idx, input logic [15:0] words [$], input int nframes);
    sb_q.delete();
    fork
      write_seq(idx, words);
      rx_frames(idx, nframes);
    join
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load  = '0;
    for (int i = 0; i < NDUT; i++) din[i] = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (dout[i] !== 16'h2000 || tx[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d: got out=%h tx=%b expected out=2000 tx=1", i, dout[i], tx[i]);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] w [$];
    w.push_back(16'h0055);
    run_case(0, w, 1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [$];
    w.push_back(16'h0041);
    w.push_back(16'h0042);
    w.push_back(16'h0043);
    run_case(0, w, 3);
  endtask

  task automatic test_overflow();
    logic [15:0] w [$];
    for (int i = 0; i < 6; i++) w.push_back(16'h0031 + 16'(i));
    w.push_back(16'h8000);
    run_case(1, w, 5);
  endtask

  task automatic test_parity();
    logic [15:0] w [$];
    w.push_back(16'h0007);
    run_case(2, w, 1);
    run_case(3, w, 1);
  endtask

  task automatic test_two_stop();
    logic [15:0] w [$];
    w.push_back(16'h00FF);
    w.push_back(16'h00FF);
    run_case(4, w, 2);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w [$];
    bit          moved;
    w.push_back(16'h0041);
    w.push_back(16'h0042);
    w.push_back(16'h0043);
    sb_q.delete();
    write_seq(0, w);
    sb_q.delete();
    // Now one clock into the start bit; 16 more clocks lands inside data bit 3.
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (tx[0] !== 1'b1 || dout[0] !== 16'h2000) begin
      errors++;
      $display("FAIL reset_mid_frame: got tx=%b out=%h expected tx=1 out=2000", tx[0], dout[0]);
    end
    moved = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || dout[0] !== 16'h2000) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL frames_after_reset: got activity expected idle with out=2000");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_two_stop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
